sync_wire_arbiter: RTL and testbench
====================================

Name: sync_wire_arbiter

Overview:
- Shares one registered output channel (DOUT/DOUT_VALID) among nreq requesters, so several rules or producers can drive a single shared datapath wire.
- Round-robin arbitration with burst locking: once granted, a requester keeps the channel until it sends a beat flagged LAST, or until a max_burst limit forces release.
- Sits between producer logic and a downstream consumer that applies ready backpressure.

Parameters:
- width, 32, data bits per beat
- nreq, 4, number of requesters (legal range 2..8)
- max_burst, 16, maximum beats per lock before forced release (legal range 1..255)

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST_N  input  1  asynchronous active-low reset
- REQ  input  nreq  per-requester beat valid
- LAST  input  nreq  per-requester final beat of burst; sampled only with REQ
- DIN  input  nreq*width  requester i data at bits [i*width +: width]
- GNT  output  nreq  one-hot or zero; combinational; a beat transfers when REQ[i] & GNT[i]
- DOUT  output  width  registered shared data
- DOUT_VALID  output  1  registered; DOUT holds a beat
- DOUT_READY  input  1  consumer accepts DOUT this cycle when DOUT_VALID
- BUSY  output  1  registered; state is LOCKED
- OVF  output  1  registered one-cycle pulse on forced release at max_burst

Behaviour:
- Reset (RST_N low, asynchronous) sets:
  - DOUT=0, DOUT_VALID=0, BUSY=0, OVF=0
  - state=IDLE, owner=0, beat_cnt=0
  - last_winner=nreq-1, so requester 0 has first priority
- can_accept = !DOUT_VALID | DOUT_READY. GNT is all zero when can_accept=0.
- IDLE state:
  - Candidate = first i with REQ[i]=1, scanning from last_winner+1 modulo nreq.
  - GNT[candidate]=1 when can_accept; GNT is 0 if no REQ is asserted.
- LOCKED state:
  - GNT[owner]=can_accept, whether or not REQ[owner] is asserted.
  - No other requester is granted, even if the owner drops REQ. The channel stalls.
- Transfer cycle (REQ[i]&GNT[i]):
  - Next edge: DOUT<=DIN[i], DOUT_VALID<=1.
  - Latency from transfer to DOUT_VALID is 1 cycle. Throughput is 1 beat/cycle with DOUT_READY held high.
- No transfer with DOUT_READY&DOUT_VALID: DOUT_VALID<=0 and DOUT holds its value.
- State transitions on a transfer by i:
  - IDLE & LAST[i] & max_burst==1: stay IDLE, last_winner<=i.
  - IDLE & !LAST[i] & max_burst>1: go LOCKED, owner<=i, beat_cnt<=1.
  - LOCKED & LAST[owner]: go IDLE, last_winner<=owner, beat_cnt<=0.
  - LOCKED & !LAST & beat_cnt+1==max_burst: go IDLE, last_winner<=owner, OVF pulses 1 cycle.
  - LOCKED otherwise: beat_cnt<=beat_cnt+1.
  - With max_burst==1, a non-LAST beat in IDLE also stays IDLE, updates last_winner and pulses OVF.
- beat_cnt width is clog2(max_burst+1). It never wraps, because release occurs at max_burst.
- Transfer is blocked while DOUT_VALID & !DOUT_READY. All GNT=0 in that case, and DOUT holds stable.
- Reset asserted mid-burst: LOCKED state is abandoned and the pending DOUT beat is dropped (DOUT_VALID=0). After release, priority restarts from requester 0.
- X on DIN of non-granted requesters must not propagate to DOUT.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=1'b0, LOCKED=1'b1
  - helper function clog2
  - rotate-priority-select function (req vector, last_winner -> index, found)
- Natural sub-module: rr_pick. Combinational nreq-way rotating priority encoder. Inputs: req, last_winner. Outputs: idx, found.
- Top holds the FSM, beat counter and output register.

Test Plan:
- Reset then REQ=4'b1111, LAST=4'b1111, DOUT_READY=1 for 4 cycles -> grants in order 0,1,2,3. DOUT follows 1 cycle later. DOUT_VALID high for 4 cycles.
- Requester 2 sends a 3-beat burst (LAST on beat 3) while REQ[0] is held high -> GNT stays on 2 for 3 beats and BUSY=1. Requester 0 is granted on the cycle after beat 3.
- DOUT_VALID=1 with DOUT_READY=0 for 5 cycles -> GNT=0, DOUT stable. Releasing READY resumes 1 beat/cycle with no loss or duplication.
- max_burst=4, requester 1 streams with LAST=0 -> after 4 beats OVF pulses once, state returns to IDLE, and the next grant goes to requester 2 if REQ[2]=1.
- RST_N dropped asynchronously mid-burst (between edges) -> DOUT_VALID, BUSY and GNT go 0 immediately. After release, the first grant goes to requester 0.
- Owner drops REQ mid-burst while REQ[3]=1 -> GNT held on owner, requester 3 not granted until owner sends LAST.

Source files
------------

// File: rtl/sync_wire_arbiter_pkg.sv
// Shared definitions for the sync_wire_arbiter block.
//   state_e    : arbiter FSM encoding (IDLE / LOCKED)
//   clog2      : elaboration-time ceil(log2(v)), minimum 1
//   rr_select  : rotating-priority pick over up to 8 requesters
package sync_wire_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int MAX_REQ = 8;

  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Scan starts one past lw and wraps at n, so the last winner has the
  // lowest priority. Requests above n-1 are never looked at.
  function automatic logic rr_select(input logic [MAX_REQ-1:0] req,
                                     input int lw, input int n,
                                     output int idx);
    logic found;
    int   i;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      i = (lw + k) % n;
      if (k <= n && !found && req[i[2:0]]) begin
        found = 1'b1;
        idx   = i;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/sync_wire_arbiter_rr_pick.sv
// Combinational rotating priority encoder.
//   req         : per-requester request vector
//   last_winner : most recent grant; scanning begins just after it
//   idx         : selected requester (valid when found)
//   found       : at least one request present
module sync_wire_arbiter_rr_pick
  import sync_wire_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_winner,
  output logic [IW-1:0]   idx,
  output logic            found
);

  logic [MAX_REQ-1:0] req_ext;
  int                 idx_i;

  assign req_ext = MAX_REQ'(req);

  always_comb begin
    idx_i = 0;
    found = rr_select(req_ext, int'(last_winner), NREQ, idx_i);
    idx   = IW'(idx_i);
  end

endmodule

// File: rtl/sync_wire_arbiter.sv
// Round-robin arbiter with burst locking onto one registered output channel.
//   CLK, RST_N      : clock, async active-low reset
//   REQ/LAST/DIN    : per-requester beat valid, end-of-burst flag, data
//   GNT             : combinational one-hot grant (zero while output blocked)
//   DOUT/DOUT_VALID : registered shared beat; DOUT_READY is consumer accept
//   BUSY            : a burst owns the channel
//   OVF             : one-cycle pulse when a burst is cut at max_burst
module sync_wire_arbiter
  import sync_wire_arbiter_pkg::*;
#(
  parameter int width     = 32,
  parameter int nreq      = 4,
  parameter int max_burst = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [nreq-1:0]       REQ,
  input  logic [nreq-1:0]       LAST,
  input  logic [nreq*width-1:0] DIN,
  output logic [nreq-1:0]       GNT,
  output logic [width-1:0]      DOUT,
  output logic                  DOUT_VALID,
  input  logic                  DOUT_READY,
  output logic                  BUSY,
  output logic                  OVF
);

  localparam int IW  = clog2(nreq);
  localparam int CW  = clog2(max_burst + 1);
  localparam bit MB1 = (max_burst == 1);

  state_e                       state_q, state_d;
  logic [IW-1:0]                owner_q, owner_d;
  logic [IW-1:0]                lw_q, lw_d;
  logic [CW-1:0]                cnt_q, cnt_d, cnt_inc;
  logic                         ovf_q, ovf_d;
  logic [width-1:0]             dout_q, dout_d;
  logic                         vld_q, vld_d;

  logic [nreq-1:0][width-1:0]   din_arr;
  logic [IW-1:0]                pick_idx, sel;
  logic                         pick_found, can_accept, xfer, last_sel;

  assign din_arr = DIN;

  sync_wire_arbiter_rr_pick #(.NREQ(nreq), .IW(IW)) u_pick (
    .req         (REQ),
    .last_winner (lw_q),
    .idx         (pick_idx),
    .found       (pick_found)
  );

  // Output process: grant is combinational. Reset is folded in so grants
  // vanish the moment RST_N falls, not at the next edge.
  always_comb begin
    can_accept = !vld_q || DOUT_READY;
    sel        = (state_q == LOCKED) ? owner_q : pick_idx;
    GNT        = '0;
    if (RST_N && can_accept && (state_q == LOCKED || pick_found))
      GNT[sel] = 1'b1;
    xfer       = |(REQ & GNT);
    last_sel   = LAST[sel];
  end

  // Next-state process: FSM, owner, rotation pointer, beat counter.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lw_d    = lw_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    cnt_inc = cnt_q + CW'(1);
    if (xfer) begin
      unique case (state_q)
        IDLE: begin
          // max_burst==1: every beat is its own burst; a non-LAST one is a cut.
          if (last_sel || MB1) begin
            lw_d  = sel;
            ovf_d = !last_sel;
          end else begin
            state_d = LOCKED;
            owner_d = sel;
            cnt_d   = CW'(1);
          end
        end
        LOCKED: begin
          if (last_sel || cnt_inc == CW'(max_burst)) begin
            state_d = IDLE;
            lw_d    = owner_q;
            cnt_d   = '0;
            ovf_d   = !last_sel;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output channel: load only the granted lane so other lanes' DIN never reach DOUT.
  always_comb begin
    dout_d = dout_q;
    vld_d  = vld_q;
    if (xfer) begin
      dout_d = din_arr[sel];
      vld_d  = 1'b1;
    end else if (DOUT_READY) begin
      vld_d = 1'b0;
    end
  end

  // State register process.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      owner_q <= '0;
      lw_q    <= IW'(nreq - 1);
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lw_q    <= lw_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_VALID = vld_q;
  assign BUSY       = (state_q == LOCKED);
  assign OVF        = ovf_q;

endmodule

// File: tb/tb_sync_wire_arbiter.sv
// Table-driven bench for sync_wire_arbiter (nreq=4, max_burst=4).
// Each row is one cycle: inputs driven after the falling edge, then the
// combinational grant and the registered outputs are compared. Granted
// beats go into a queue and are matched against DOUT when it is presented.
module tb_sync_wire_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int MB = 4;

  logic           CLK = 1'b0;
  logic           RST_N;
  logic [N-1:0]   REQ, LAST, GNT;
  logic [N*W-1:0] DIN;
  logic [W-1:0]   DOUT;
  logic           DOUT_VALID, DOUT_READY, BUSY, OVF;

  sync_wire_arbiter #(.width(W), .nreq(N), .max_burst(MB)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REQ        (REQ),
    .LAST       (LAST),
    .DIN        (DIN),
    .GNT        (GNT),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_READY (DOUT_READY),
    .BUSY       (BUSY),
    .OVF        (OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] last;
    logic         rdy;
    logic [N-1:0] gnt;
    logic         vld;
    logic         busy;
    logic         ovf;
  } row_t;

  row_t       tbl[$];
  logic [W-1:0] sb[$];
  int         errors = 0;
  int         checks = 0;

  function automatic void add(input logic [N-1:0] req, input logic [N-1:0] last,
                              input logic rdy, input logic [N-1:0] gnt,
                              input logic vld, input logic busy, input logic ovf);
    row_t r;
    r.req = req; r.last = last; r.rdy = rdy;
    r.gnt = gnt; r.vld = vld; r.busy = busy; r.ovf = ovf;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_row(input int n, input row_t r);
    logic [W-1:0] dv[N];
    @(negedge CLK);
    REQ = r.req; LAST = r.last; DOUT_READY = r.rdy;
    for (int i = 0; i < N; i++) begin
      dv[i] = $urandom;
      DIN[i*W +: W] = dv[i];
    end
    #1;
    chk($sformatf("row%0d gnt", n),  W'(GNT),        W'(r.gnt));
    chk($sformatf("row%0d vld", n),  W'(DOUT_VALID), W'(r.vld));
    chk($sformatf("row%0d busy", n), W'(BUSY),       W'(r.busy));
    chk($sformatf("row%0d ovf", n),  W'(OVF),        W'(r.ovf));
    if (r.vld) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL row%0d dout: got %0h expected none queued", n, DOUT);
      end else begin
        chk($sformatf("row%0d dout", n), DOUT, sb[0]);
        if (r.rdy) void'(sb.pop_front());
      end
    end
    for (int i = 0; i < N; i++)
      if (r.req[i] && r.gnt[i]) sb.push_back(dv[i]);
  endtask

  initial begin
    RST_N = 1'b0; REQ = '1; LAST = '1; DIN = '0; DOUT_READY = 1'b1;
    #12;
    chk("rst gnt",  W'(GNT), 0);
    chk("rst vld",  W'(DOUT_VALID), 0);
    chk("rst busy", W'(BUSY), 0);
    chk("rst ovf",  W'(OVF), 0);
    chk("rst dout", DOUT, 0);
    REQ = '0;
    @(negedge CLK); RST_N = 1'b1;

    // req      last     rdy  gnt      vld busy ovf
    // round robin, single-beat bursts
    add(4'b1111, 4'b1111, 1, 4'b0001, 0, 0, 0);
    add(4'b1111, 4'b1111, 1, 4'b0010, 1, 0, 0);
    add(4'b1111, 4'b1111, 1, 4'b0100, 1, 0, 0);
    add(4'b1111, 4'b1111, 1, 4'b1000, 1, 0, 0);
    add(4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 0);
    // 3-beat burst from 2 while 0 waits
    add(4'b0100, 4'b0000, 1, 4'b0100, 0, 0, 0);
    add(4'b0101, 4'b0000, 1, 4'b0100, 1, 1, 0);
    add(4'b0101, 4'b0100, 1, 4'b0100, 1, 1, 0);
    add(4'b0001, 4'b0001, 1, 4'b0001, 1, 0, 0);
    add(4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 0);
    // 5-cycle backpressure stall
    add(4'b0010, 4'b0010, 1, 4'b0010, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      add(4'b0100, 4'b0100, 0, 4'b0000, 1, 0, 0);
    add(4'b0100, 4'b0100, 1, 4'b0100, 1, 0, 0);
    add(4'b1000, 4'b1000, 1, 4'b1000, 1, 0, 0);
    add(4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 0);
    // requester 1 streams without LAST: cut after 4 beats, then 2 wins
    add(4'b0110, 4'b0000, 1, 4'b0010, 0, 0, 0);
    add(4'b0110, 4'b0000, 1, 4'b0010, 1, 1, 0);
    add(4'b0110, 4'b0000, 1, 4'b0010, 1, 1, 0);
    add(4'b0110, 4'b0000, 1, 4'b0010, 1, 1, 0);
    add(4'b0110, 4'b0100, 1, 4'b0100, 1, 0, 1);
    add(4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 0);
    // owner 0 drops REQ mid-burst; 3 must wait for LAST
    add(4'b0001, 4'b0000, 1, 4'b0001, 0, 0, 0);
    add(4'b1000, 4'b0000, 1, 4'b0001, 1, 1, 0);
    add(4'b1000, 4'b0000, 1, 4'b0001, 0, 1, 0);
    add(4'b1001, 4'b0001, 1, 4'b0001, 0, 1, 0);
    add(4'b1000, 4'b1000, 1, 4'b1000, 1, 0, 0);
    add(4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 0);
    // start a burst from 2, to be killed by reset
    add(4'b0100, 4'b0000, 1, 4'b0100, 0, 0, 0);

    for (int n = 0; n < tbl.size(); n++) run_row(n, tbl[n]);

    // async reset between edges, mid-burst
    @(posedge CLK); #2;
    chk("pre-rst busy", W'(BUSY), 1);
    chk("pre-rst vld",  W'(DOUT_VALID), 1);
    chk("pre-rst gnt",  W'(GNT), W'(4'b0100));
    REQ = '0; RST_N = 1'b0; #1;
    chk("mid-rst vld",  W'(DOUT_VALID), 0);
    chk("mid-rst busy", W'(BUSY), 0);
    chk("mid-rst gnt",  W'(GNT), 0);
    chk("mid-rst dout", DOUT, 0);
    sb.delete();
    @(posedge CLK);
    @(negedge CLK); RST_N = 1'b1;

    tbl.delete();
    add(4'b1111, 4'b1111, 1, 4'b0001, 0, 0, 0);
    add(4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 0);
    add(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
    for (int n = 0; n < tbl.size(); n++) run_row(100 + n, tbl[n]);

    chk("sb drained", W'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
